// File: rtl/cpu_out_display.sv
// Converts the CPU output byte to decimal with a serial shift-and-add-3 engine
// and drives a 4-digit multiplexed active-low seven-segment display.
module cpu_out_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        boardCLK,
  input  logic        reset,
  input  logic [7:0]  cpuOut,
  input  logic        signedMode,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  last_value_reg, last_value_next;
  logic        last_mode_reg, last_mode_next;
  logic        neg_flag_reg, neg_flag_next;
  logic        neg_pend_reg, neg_pend_next;
  logic [11:0] bcd_reg, bcd_next;
  logic [11:0] scratch_reg, scratch_next;
  logic [7:0]  mag_reg, mag_next;
  logic [2:0]  count_reg, count_next;
  logic [CW-1:0] refresh_reg;
  logic [1:0]  index_reg;
  logic [11:0] adjusted;

  // Add-3 correction on every BCD nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adjusted[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                                   scratch_reg[gi*4 +: 4] + 4'd3 :
                                   scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_value_reg <= 8'd0;
      last_mode_reg  <= 1'b0;
      neg_flag_reg   <= 1'b0;
      neg_pend_reg   <= 1'b0;
      bcd_reg        <= 12'd0;
      scratch_reg    <= 12'd0;
      mag_reg        <= 8'd0;
      count_reg      <= 3'd0;
    end else begin
      state_reg      <= state_next;
      last_value_reg <= last_value_next;
      last_mode_reg  <= last_mode_next;
      neg_flag_reg   <= neg_flag_next;
      neg_pend_reg   <= neg_pend_next;
      bcd_reg        <= bcd_next;
      scratch_reg    <= scratch_next;
      mag_reg        <= mag_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_value_next = last_value_reg;
    last_mode_next  = last_mode_reg;
    neg_flag_next   = neg_flag_reg;
    neg_pend_next   = neg_pend_reg;
    bcd_next        = bcd_reg;
    scratch_next    = scratch_reg;
    mag_next        = mag_reg;
    count_next      = count_reg;
    case (state_reg)
      IDLE: begin
        if ({cpuOut, signedMode} != {last_value_reg, last_mode_reg}) begin
          last_value_next = cpuOut;
          last_mode_next  = signedMode;
          if (signedMode && cpuOut[7]) begin
            mag_next      = ~cpuOut + 8'd1;
            neg_pend_next = 1'b1;
          end else begin
            mag_next      = cpuOut;
            neg_pend_next = 1'b0;
          end
          scratch_next = 12'd0;
          count_next   = 3'd0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_next = {adjusted[10:0], mag_reg[7]};
        mag_next     = {mag_reg[6:0], 1'b0};
        count_next   = count_reg + 3'd1;
        if (count_reg == 3'd7) state_next = DONE;
      end
      DONE: begin
        bcd_next      = scratch_reg;
        neg_flag_next = neg_pend_reg;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Refresh timing is free-running and independent of the converter.
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      refresh_reg <= '0;
      index_reg   <= 2'd0;
    end else if (refresh_reg == REFRESH_MAX) begin
      refresh_reg <= '0;
      index_reg   <= index_reg + 2'd1;
    end else begin
      refresh_reg <= refresh_reg + 1'b1;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Leading-zero blanking: tens only blank when hundreds is also zero.
  always_comb begin
    an  = ~(4'b0001 << index_reg);
    seg = SEG_BLANK;
    case (index_reg)
      2'd0: seg = seg_of(bcd_reg[3:0]);
      2'd1: seg = (bcd_reg[11:4] == 8'd0) ? SEG_BLANK : seg_of(bcd_reg[7:4]);
      2'd2: seg = (bcd_reg[11:8] == 4'd0) ? SEG_BLANK : seg_of(bcd_reg[11:8]);
      default: seg = neg_flag_reg ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  assign dp   = 1'b1;
  assign bcd  = bcd_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_cpu_out_display.sv
// Self-checking bench for cpu_out_display: decimal/timing model plus directed vectors.
module tb_cpu_out_display;

  localparam int RD = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  cpu_out = 8'd0;
  logic        signed_mode = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [11:0] bcd;
  logic        busy;

  cpu_out_display #(.REFRESH_DIV(RD)) dut (
    .boardCLK  (clk),
    .reset     (rst),
    .cpuOut    (cpu_out),
    .signedMode(signed_mode),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .bcd       (bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic mon_on = 1'b0;

  logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] an_tab [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of the byte as the display should show it.
  function automatic logic [11:0] to_bcd(input logic [7:0] v, input logic m);
    int mag;
    mag = (m && v[7]) ? 256 - int'(v) : int'(v);
    return {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input logic [11:0] b, input logic neg);
    case (idx)
      0:       return pat[int'(b[3:0])];
      1:       return (b[11:4] == 8'd0) ? BLANK : pat[int'(b[7:4])];
      2:       return (b[11:8] == 4'd0) ? BLANK : pat[int'(b[11:8])];
      default: return neg ? MINUS : BLANK;
    endcase
  endfunction

  // Transaction-level model: a conversion takes 9 cycles, then the result appears.
  logic [7:0]  m_last_val;
  logic        m_last_mode;
  int          m_cnt;
  logic [11:0] m_bcd;
  logic        m_neg;
  int          m_cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last_val  <= 8'd0;
      m_last_mode <= 1'b0;
      m_cnt       <= 0;
      m_bcd       <= 12'd0;
      m_neg       <= 1'b0;
      m_cyc       <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cnt == 0) begin
        if (cpu_out != m_last_val || signed_mode != m_last_mode) begin
          m_last_val  <= cpu_out;
          m_last_mode <= signed_mode;
          m_cnt       <= 9;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_bcd <= to_bcd(m_last_val, m_last_mode);
          m_neg <= m_last_mode && m_last_val[7];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      automatic int idx = (m_cyc / RD) % 4;
      chk("bcd", 32'(bcd), 32'(m_bcd));
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("an", 32'(an), 32'(an_tab[idx]));
      chk("seg", 32'(seg), 32'(exp_seg(idx, m_bcd, m_neg)));
      chk("dp", 32'(dp), 32'd1);
    end
  end

  task automatic convert(input logic [7:0] v, input logic m,
                         input logic [11:0] exp_bcd, input logic [6:0] exp_sign);
    int busy_cnt;
    bit found;
    @(negedge clk);
    cpu_out     = v;
    signed_mode = m;
    busy_cnt    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd9);
    chk("bcd_lit", 32'(bcd), 32'(exp_bcd));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b0111) found = 1'b1;
    end
    chk("sign_digit_seen", 32'(found), 32'd1);
    if (found) chk("sign_seg", 32'(seg), 32'(exp_sign));
    $display("[TB] cpuOut=%02h signed=%0b -> bcd=%03h busy_cycles=%0d sign=%07b",
             v, m, bcd, busy_cnt, seg);
  endtask

  initial begin
    int busy_cnt;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dp", 32'(dp), 32'd1);
    $display("[TB] reset: an=%04b seg=%07b bcd=%03h busy=%0b", an, seg, bcd, busy);
    rst = 1'b0;

    // Digit rotation from reset, with zero shown only on the ones digit.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("an_rot", 32'(an), 32'(an_tab[(k / 4) % 4]));
      chk("seg_zero", 32'(seg), 32'(((k / 4) % 4 == 0) ? 7'b1000000 : BLANK));
    end
    $display("[TB] refresh rotation checked over 16 cycles");

    convert(8'hE1, 1'b0, 12'h225, BLANK);
    convert(8'hE1, 1'b1, 12'h031, MINUS);
    convert(8'h80, 1'b1, 12'h128, MINUS);
    convert(8'h7F, 1'b1, 12'h127, BLANK);
    convert(8'h00, 1'b1, 12'h000, BLANK);
    convert(8'h00, 1'b0, 12'h000, BLANK);

    // Unchanged input must not retrigger.
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("no_retrigger", 32'(busy_cnt), 32'd0);
    $display("[TB] hold 00/unsigned: busy_cycles=%0d", busy_cnt);

    // Back-to-back: second change waits for the first conversion.
    @(negedge clk);
    cpu_out = 8'h23;
    repeat (2) @(negedge clk);
    cpu_out = 8'hE1;
    repeat (8) @(negedge clk);
    chk("b2b_first", 32'(bcd), 32'(12'h035));
    repeat (9) @(negedge clk);
    chk("b2b_hold", 32'(bcd), 32'(12'h035));
    @(negedge clk);
    chk("b2b_second", 32'(bcd), 32'(12'h225));
    $display("[TB] back-to-back 23 then E1 -> bcd=%03h", bcd);

    // Reset in the middle of a conversion.
    @(negedge clk);
    cpu_out = 8'h55;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    chk("midrst_an", 32'(an), 32'(4'b1110));
    chk("midrst_seg", 32'(seg), 32'(7'b1000000));
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_conv", 32'(bcd), 32'(12'h085));
    $display("[TB] reset mid-conversion, then 55 -> bcd=%03h", bcd);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
